// File: rtl/mcpu_mem_atom_responder.sv
// mcpu_mem_atom_responder: line SRAM responder, fixed LATENCY, stall while busy; MCPU_MEM_ATOM_RANGE_CHECK_EN adds atom_err on out-of-range addresses
module mcpu_mem_atom_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY = 2
) (
  input  logic         clkrst_mem_clk,
  input  logic         clkrst_mem_rst,
  input  logic         atom_valid,
  input  logic [2:0]   atom_opcode,
  input  logic [26:0]  atom_addr,
  input  logic [255:0] atom_wdata,
  input  logic [31:0]  atom_wbe,
  output logic [255:0] atom_rdata,
  output logic         atom_rvalid,
  output logic         atom_stall,
  output logic         atom_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [255:0] mem [2**ADDR_WIDTH];
  logic [255:0] resp;
  logic err_q, oor, accept, rd, wr;
  logic [ADDR_WIDTH-1:0] idx;
  assign idx = atom_addr[ADDR_WIDTH-1:0];
`ifdef MCPU_MEM_ATOM_RANGE_CHECK_EN
  assign oor = |atom_addr[26:ADDR_WIDTH];
`else
  logic unused_hi;
  assign unused_hi = ^atom_addr[26:ADDR_WIDTH];
  assign oor = 1'b0;
`endif
  assign atom_stall = state == BUSY;
  assign accept = atom_valid & ~atom_stall;
  assign rd = accept & (atom_opcode == 3'b000) & ~oor;
  assign wr = accept & (atom_opcode == 3'b001) & ~oor;
  assign atom_rvalid = atom_stall & (cnt == 4'd0);
  assign atom_rdata = atom_rvalid ? resp : '0;
  assign atom_err = atom_rvalid & err_q;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    state_d = accept ? BUSY : atom_rvalid ? IDLE : state;
    cnt_d = accept ? 4'(LATENCY - 1) : cnt - {3'b0, atom_stall & (cnt != 4'd0)};
  end
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      state <= IDLE;
      cnt <= '0;
      resp <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (accept) begin
        resp <= rd ? mem[idx] : '0;
        err_q <= oor;
      end
    end
  end
  always_ff @(posedge clkrst_mem_clk) begin
    if (wr)
      for (int i = 0; i < 32; i++)
        if (atom_wbe[i]) mem[idx][8*i +: 8] <= atom_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_mcpu_mem_atom_responder.sv
// tb_mcpu_mem_atom_responder: scoreboard bench for the memory atom responder
module tb_mcpu_mem_atom_responder;
  localparam int AW = 10;
  localparam int L = 2;
  logic clk = 0, rst = 1, valid = 0;
  logic [2:0] opcode = '0;
  logic [26:0] addr = '0;
  logic [255:0] wdata = '0, rdata;
  logic [31:0] wbe = '0;
  logic rvalid, stall, err;
  typedef struct {logic [255:0] d; logic e;} exp_t;
  exp_t sb[$];
  int n = 0, fails = 0;
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] MIX = {{28{8'hA5}}, 32'h44332211};
  localparam logic [255:0] P = {8{32'hDEADBEEF}};
  localparam logic [255:0] Q = {16{16'h5A3C}};
  localparam logic [255:0] X = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] Y = {32{8'h7E}};

  mcpu_mem_atom_responder #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (
    .clkrst_mem_clk(clk), .clkrst_mem_rst(rst), .atom_valid(valid), .atom_opcode(opcode),
    .atom_addr(addr), .atom_wdata(wdata), .atom_wbe(wbe), .atom_rdata(rdata),
    .atom_rvalid(rvalid), .atom_stall(stall), .atom_err(err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid) begin
        n++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rvalid: got rdata %h err %b want no response", rdata, err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rdata !== e.d || err !== e.e) begin
            fails++;
            $display("FAIL response: got rdata %h err %b want %h err %b", rdata, err, e.d, e.e);
          end
        end
      end else if (rdata !== '0 || err !== 1'b0) begin
        fails++;
        $display("FAIL idle_outputs: got rdata %h err %b want 0", rdata, err);
      end
    end
  end

  task automatic req(input logic [2:0] op, input logic [26:0] a, input logic [255:0] wd,
                     input logic [31:0] be, input logic [255:0] ed, input logic ee, input bit timing);
    int g = 0;
    valid = 1; opcode = op; addr = a; wdata = wd; wbe = be;
    while (stall && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) begin n++; fails++; $display("FAIL accept_timeout: stall stuck high"); end
    sb.push_back('{d: ed, e: ee});
    @(posedge clk);
    #1 valid = 0; opcode = 3'b001; addr = ~a; wdata = ~wd; wbe = '1;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (timing) begin
        chk("stall_busy", 256'(stall), 256'(1));
        chk("rvalid_slot", 256'(rvalid), 256'(k == L));
      end
    end
    @(negedge clk);
    if (timing) chk("stall_released", 256'(stall), 256'(0));
  endtask

  task automatic drain;
    int g = 0;
    while ((sb.size() != 0 || stall) && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) begin n++; fails++; $display("FAIL drain_timeout: %0d responses outstanding", sb.size()); end
  endtask

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_stall", 256'(stall), 256'(0));
      chk("reset_rvalid", 256'(rvalid), 256'(0));
      chk("reset_rdata", rdata, '0);
    end
    req(3'b001, 27'h010, A5, '1, '0, 0, 1);
    req(3'b000, 27'h010, '0, '0, A5, 0, 1);
    req(3'b001, 27'h010, {224'h0, 32'h44332211}, 32'h0000000F, '0, 0, 0);
    req(3'b000, 27'h010, '0, '0, MIX, 0, 0);
    req(3'b001, 27'h010, '0, 32'h0, '0, 0, 0);
    req(3'b000, 27'h010, '0, '0, MIX, 0, 0);
    req(3'b101, 27'h010, '0, '1, '0, 0, 1);
    req(3'b000, 27'h010, '0, '0, MIX, 0, 0);
    req(3'b001, 27'h020, P, '1, '0, 0, 0);
    valid = 1; opcode = 3'b000; addr = 27'h020; wbe = '1;
    for (int i = 0; i < 4; i++) sb.push_back('{d: P, e: 1'b0});
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (!stall) acc++;
      @(negedge clk);
    end
    valid = 0;
    chk("held_valid_accepts", 256'(acc), 256'(4));
    drain();
    req(3'b001, 27'h030, Q, '1, '0, 0, 0);
    valid = 1; opcode = 3'b000; addr = 27'h030;
    @(posedge clk);
    #1 valid = 0; rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("stall_after_reset", 256'(stall), 256'(0));
    repeat (3) begin
      @(negedge clk);
      chk("no_rvalid_after_reset", 256'(rvalid), 256'(0));
    end
    req(3'b000, 27'h030, '0, '0, Q, 0, 0);
    req(3'b001, 27'h000, Y, '1, '0, 0, 0);
`ifdef MCPU_MEM_ATOM_RANGE_CHECK_EN
    req(3'b001, 27'h400, X, '1, '0, 1, 0);
    req(3'b000, 27'h000, '0, '0, Y, 0, 0);
`else
    req(3'b001, 27'h400, X, '1, '0, 0, 0);
    req(3'b000, 27'h000, '0, '0, X, 0, 0);
`endif
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
